alink_master: RTL and testbench

Wishbone classic-cycle initiator that drives the ALINK register slave (TXFIFO/STATE/MASK/BUSY/RXFIFO) from a simple single-word request/response port. It sits between the host-side command sequencer and the ALINK slave's `ALINK_*_I` port. It converts each accepted request into one Wishbone read or write and returns read data plus a status code. It also handles ERR, RTY and a bus timeout.

---
 rtl/alink_pkg.sv | 27 ++
 rtl/alink_wb_timer.sv | 38 +++
 rtl/alink_master.sv | 182 ++++++++++++++++++
 tb/tb_alink_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alink_pkg.sv
// Shared definitions for the ALINK Wishbone initiator.
//   - status codes returned on rsp_status
//   - FSM state encoding of alink_master
//   - register map of the ALINK slave
package alink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_ERR     = 2'd1;
  localparam logic [1:0] STATUS_RETRY   = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  localparam logic [5:0] ADR_TXFIFO = 6'h00;
  localparam logic [5:0] ADR_STATE  = 6'h04;
  localparam logic [5:0] ADR_MASK   = 6'h08;
  localparam logic [5:0] ADR_BUSY   = 6'h0c;
  localparam logic [5:0] ADR_RXFIFO = 6'h10;

  localparam int TMR_W = 8;

endpackage

// File: rtl/alink_wb_timer.sv
// Bus-phase timeout counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : count <= 1 (first cycle of a strobe); wins over clr/inc
//   clr        : count <= 0
//   inc        : count <= count + 1, saturating at all-ones
//   expired    : count has reached TIMEOUT
//   count      : current value
// The count equals the number of cycles the strobe has been high, so the
// master aborts on the edge where expired is seen.
module alink_wb_timer
  import alink_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic             inc,
  output logic             expired,
  output logic [TMR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= TMR_W'(1);
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {TMR_W{1'b1}})) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expired = (count == TMR_W'(TIMEOUT));

endmodule

// File: rtl/alink_master.sv
// Wishbone classic-cycle initiator for the ALINK register slave.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (req_we, req_adr, req_dat)
//   rsp_valid/rsp_ready        : response handshake (rsp_dat, rsp_status)
//   ALINK_*_O                  : Wishbone initiator outputs (all registered)
//   ALINK_ACK/ERR/RTY_I, DAT_I : Wishbone slave terminations and read data
//   dbg_state                  : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is held with its payload until that edge.
module alink_master
  import alink_pkg::*;
#(
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [5:0]  req_adr,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        ALINK_CYC_O,
  output logic        ALINK_STB_O,
  output logic        ALINK_WE_O,
  output logic [5:0]  ALINK_ADR_O,
  output logic [31:0] ALINK_DAT_O,
  output logic [3:0]  ALINK_SEL_O,
  output logic [2:0]  ALINK_CTI_O,
  output logic [1:0]  ALINK_BTE_O,
  output logic        ALINK_LOCK_O,
  input  logic        ALINK_ACK_I,
  input  logic        ALINK_ERR_I,
  input  logic        ALINK_RTY_I,
  input  logic [31:0] ALINK_DAT_I,
  output logic [1:0]  dbg_state
);

  state_t      state, state_n;
  logic        cyc_q, cyc_n;       // CYC and STB always move together
  logic        we_q, we_n;
  logic [5:0]  adr_q, adr_n;
  logic [31:0] dat_q, dat_n;
  logic        req_ready_q, req_ready_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [31:0] rsp_dat_q, rsp_dat_n;
  logic [1:0]  rsp_status_q, rsp_status_n;
  logic [3:0]  retry_q, retry_n;

  logic             tmr_load, tmr_clr, tmr_inc, tmr_expired;
  logic [TMR_W-1:0] tmr_count;

  alink_wb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired),
    .count   (tmr_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= STATUS_OK;
      retry_q      <= '0;
    end else begin
      state        <= state_n;
      cyc_q        <= cyc_n;
      we_q         <= we_n;
      adr_q        <= adr_n;
      dat_q        <= dat_n;
      req_ready_q  <= req_ready_n;
      rsp_valid_q  <= rsp_valid_n;
      rsp_dat_q    <= rsp_dat_n;
      rsp_status_q <= rsp_status_n;
      retry_q      <= retry_n;
    end
  end

  always_comb begin
    state_n      = state;
    cyc_n        = cyc_q;
    we_n         = we_q;
    adr_n        = adr_q;
    dat_n        = dat_q;
    req_ready_n  = req_ready_q;
    rsp_valid_n  = rsp_valid_q;
    rsp_dat_n    = rsp_dat_q;
    rsp_status_n = rsp_status_q;
    retry_n      = retry_q;
    tmr_load     = 1'b0;
    tmr_inc      = 1'b0;
    tmr_clr      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid && req_ready_q) begin
          we_n        = req_we;
          adr_n       = req_adr;
          dat_n       = req_dat;
          retry_n     = '0;
          cyc_n       = 1'b1;
          req_ready_n = 1'b0;
          tmr_load    = 1'b1;
          state_n     = ST_BUS;
        end
      end
      ST_BUS: begin
        // Any termination (or timeout) drops the strobe on this edge; the
        // default exit is a response, a retry below overrides it to GAP.
        if (ALINK_ERR_I || ALINK_RTY_I || ALINK_ACK_I || tmr_expired) begin
          cyc_n       = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_dat_n   = '0;
          state_n     = ST_RESP;
        end else begin
          tmr_inc = 1'b1;
        end
        if (ALINK_ERR_I) begin
          rsp_status_n = STATUS_ERR;
        end else if (ALINK_RTY_I) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_n     = retry_q + 4'd1;
            rsp_valid_n = 1'b0;
            state_n     = ST_GAP;
          end else begin
            rsp_status_n = STATUS_RETRY;
          end
        end else if (ALINK_ACK_I) begin
          rsp_status_n = STATUS_OK;
          if (!we_q) rsp_dat_n = ALINK_DAT_I;
        end else if (tmr_expired) begin
          rsp_status_n = STATUS_TIMEOUT;
        end
      end
      ST_GAP: begin
        cyc_n    = 1'b1;
        tmr_load = 1'b1;
        state_n  = ST_BUS;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Counter is zero whenever no strobe is outstanding (load still wins).
    if (state_n != ST_BUS) tmr_clr = 1'b1;
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_dat      = rsp_dat_q;
  assign rsp_status   = rsp_status_q;
  assign ALINK_CYC_O  = cyc_q;
  assign ALINK_STB_O  = cyc_q;
  assign ALINK_WE_O   = we_q;
  assign ALINK_ADR_O  = adr_q;
  assign ALINK_DAT_O  = dat_q;
  assign ALINK_SEL_O  = 4'hf;
  assign ALINK_CTI_O  = 3'd0;
  assign ALINK_BTE_O  = 2'd0;
  assign ALINK_LOCK_O = 1'b0;
  assign dbg_state    = state;

endmodule

// File: tb/tb_alink_master.sv
module tb_alink_master;
  import alink_pkg::*;

  localparam int TIMEOUT   = 15;
  localparam int MAX_RETRY = 3;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [5:0]  req_adr = '0;
  logic [31:0] req_dat = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        cyc_o, stb_o, we_o, lock_o;
  logic [5:0]  adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic [1:0]  dbg_state;

  alink_master #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .ALINK_CYC_O(cyc_o), .ALINK_STB_O(stb_o), .ALINK_WE_O(we_o),
    .ALINK_ADR_O(adr_o), .ALINK_DAT_O(dat_o), .ALINK_SEL_O(sel_o),
    .ALINK_CTI_O(cti_o), .ALINK_BTE_O(bte_o), .ALINK_LOCK_O(lock_o),
    .ALINK_ACK_I(ack_i), .ALINK_ERR_I(err_i), .ALINK_RTY_I(rty_i),
    .ALINK_DAT_I(dat_i), .dbg_state(dbg_state)
  );

  // ---------------- slave responder ----------------
  // Behaves like a registered slave: terminates 1+s_delay cycles after it
  // first sees STB, holds the termination for one cycle only. Driven on the
  // falling edge so the master sees it at the following rising edge.
  int          s_rty_n = 0, s_kind = K_ACK, s_delay = 0, s_pulse = 0;
  int          s_wcnt = 0;
  logic [31:0] s_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; s_wcnt = 0;
    end else if (ack_i || err_i || rty_i) begin
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; s_wcnt = 0;
      dat_i = $urandom;
    end else if (stb_o) begin
      if (s_wcnt >= 1 + s_delay) begin
        if (s_pulse < s_rty_n) begin
          rty_i = 1'b1; s_pulse++;
        end else if (s_kind == K_ACK) begin
          ack_i = 1'b1; dat_i = s_data; s_pulse++;
        end else if (s_kind == K_ERR) begin
          err_i = 1'b1; s_pulse++;
        end else if (s_kind == K_BOTH) begin
          ack_i = 1'b1; err_i = 1'b1; dat_i = s_data; s_pulse++;
        end
      end else begin
        s_wcnt++;
      end
    end else begin
      s_wcnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];
  logic [0:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req_ready(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // One request, checked against a model built from the bus rules: pulse
  // lengths, gaps, final status and data all derived from the slave script.
  task automatic run_txn(input string tag, input logic we, input logic [5:0] adr,
                         input logic [31:0] dat, input int rty_n, input int kind,
                         input int delay, input logic [31:0] sdata, input int hold);
    int          pulses, c, bus_bad;
    logic        got, match;
    logic [1:0]  e_status;
    logic [31:0] e_data;
    s_rty_n = rty_n; s_kind = kind; s_delay = delay; s_data = sdata; s_pulse = 0;

    // reference model
    exp_q.delete();
    obs_q.delete();
    pulses = (rty_n > MAX_RETRY) ? MAX_RETRY + 1 : rty_n + 1;
    if (rty_n > MAX_RETRY)   e_status = STATUS_RETRY;
    else if (kind == K_ACK)  e_status = STATUS_OK;
    else if (kind == K_NONE) e_status = STATUS_TIMEOUT;
    else                     e_status = STATUS_ERR;
    e_data = (e_status == STATUS_OK && !we) ? sdata : 32'd0;
    for (int p = 0; p < pulses; p++) begin
      int len;
      len = (p == pulses - 1 && e_status == STATUS_TIMEOUT) ? TIMEOUT : 2 + delay;
      for (int k = 0; k < len; k++) exp_q.push_back(1'b1);
      if (p != pulses - 1) exp_q.push_back(1'b0);
    end

    wait_req_ready(tag);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_adr = $urandom; req_dat = $urandom;

    c = 0; got = 1'b0; bus_bad = 0;
    while (c < 300) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      obs_q.push_back(stb_o);
      if (cyc_o !== stb_o) bus_bad++;
      if (stb_o && (we_o !== we || adr_o !== adr || dat_o !== dat)) bus_bad++;
      c++;
      @(negedge clk);
    end
    check({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, c, exp_q.size());
    match = (obs_q.size() == exp_q.size());
    if (match) foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) match = 1'b0;
    check({tag, "_stb_pattern"}, {31'd0, match}, 32'd1);
    check({tag, "_bus_fields"}, bus_bad, 0);
    check({tag, "_status"}, {30'd0, rsp_status}, {30'd0, e_status});
    check({tag, "_rsp_dat"}, rsp_dat, e_data);
    check({tag, "_stb_low_in_resp"}, {31'd0, stb_o}, 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_dat"}, rsp_dat, e_data);
      check({tag, "_hold_status"}, {30'd0, rsp_status}, {30'd0, e_status});
      check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] adr_tab[5];
    adr_tab[0] = ADR_TXFIFO; adr_tab[1] = ADR_STATE; adr_tab[2] = ADR_MASK;
    adr_tab[3] = ADR_BUSY;   adr_tab[4] = ADR_RXFIFO;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, cyc_o}, 32'd0);
    check("rst_stb", {31'd0, stb_o}, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_adr", {26'd0, adr_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_sel", {28'd0, sel_o}, 32'hf);
    check("rst_cti", {29'd0, cti_o}, 32'd0);
    check("rst_bte", {30'd0, bte_o}, 32'd0);
    check("rst_lock", {31'd0, lock_o}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst_n = 1'b1;

    run_txn("rd_state", 1'b0, ADR_STATE, 32'h0, 0, K_ACK, 0, 32'h0005_0002, 0);
    run_txn("wr_mask", 1'b1, ADR_MASK, 32'hffff_0000, 0, K_ACK, 0, 32'hdead_beef, 0);
    run_txn("rty2_ack", 1'b0, ADR_RXFIFO, 32'h0, 2, K_ACK, 0, 32'h1234_5678, 0);
    run_txn("rty_exh", 1'b1, ADR_TXFIFO, 32'h0bad_cafe, 5, K_ACK, 0, 32'h1, 0);
    run_txn("timeout", 1'b0, ADR_BUSY, 32'h0, 0, K_NONE, 0, 32'h0, 0);
    run_txn("after_to", 1'b0, ADR_STATE, 32'h0, 0, K_ACK, 1, 32'h0000_00a5, 0);
    run_txn("ack_err", 1'b0, ADR_STATE, 32'h0, 0, K_BOTH, 0, 32'h7777_7777, 5);

    // reset while the bus phase is outstanding
    s_rty_n = 0; s_kind = K_NONE; s_delay = 0; s_pulse = 0;
    wait_req_ready("mid_rst");
    req_valid = 1'b1; req_we = 1'b0; req_adr = ADR_BUSY;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_stb_before", {31'd0, stb_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cyc", {31'd0, cyc_o}, 32'd0);
    check("mid_rst_stb", {31'd0, stb_o}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    run_txn("post_rst_rx", 1'b0, ADR_RXFIFO, 32'h0, 0, K_ACK, 0, 32'hc0de_0042, 0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      kind = (kind < 5) ? K_ACK : (kind < 7) ? K_ERR : (kind < 9) ? K_BOTH : K_NONE;
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
              adr_tab[$urandom_range(0, 4)], $urandom, $urandom_range(0, 5),
              kind, $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
